// File: rtl/armleocpu_fetch_responder_pkg.sv
// Shared command/response codes for the fetch-to-cache interface and
// small helpers used by the fetch responder and its line buffer.
package armleocpu_fetch_responder_pkg;

    // Commands issued by the fetch unit
    localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
    localparam logic [3:0] CACHE_CMD_LOAD      = 4'd2;
    localparam logic [3:0] CACHE_CMD_STORE     = 4'd3;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

    // Responses returned to the fetch unit
    localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
    localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd4;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd5;

    // Word-index width of a line; at least one bit so a one-word line
    // still has a usable beat counter.
    function automatic int beat_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/armleocpu_line_buffer.sv
// Single instruction line: WORDS_PER_LINE x 32 storage with one write port
// and a combinational read port, plus the valid bit and tag of the line.
module armleocpu_line_buffer
    import armleocpu_fetch_responder_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = 2,
    parameter int TAG_W          = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata,
    input  logic             valid_set,
    input  logic             valid_clear,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_in,
    output logic             line_valid,
    output logic [TAG_W-1:0] tag
);

    logic [31:0]      word_reg [WORDS_PER_LINE];
    logic             valid_reg;
    logic [TAG_W-1:0] tag_reg;

    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            // Each word captures the bus beat addressed to it
            always_ff @(posedge clk) begin
                if (we && (widx == IDX_W'(gi))) begin
                    word_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Read mux by word index; loop bound keeps indexing in range for any size
    always_comb begin
        rdata = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = word_reg[i];
            end
        end
    end

    // Line valid/tag tracking; clear wins so a refill start always invalidates
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
        end else begin
            if (valid_clear) begin
                valid_reg <= 1'b0;
            end else if (valid_set) begin
                valid_reg <= 1'b1;
            end
            if (tag_we) begin
                tag_reg <= tag_in;
            end
        end
    end

    assign line_valid = valid_reg;
    assign tag        = tag_reg;

endmodule

// File: rtl/armleocpu_fetch_responder.sv
// Fetch responder: serves EXECUTE/FLUSH_ALL from one buffered line and
// refills that line from backing memory, word 0 first, on a miss.
module armleocpu_fetch_responder
    import armleocpu_fetch_responder_pkg::*;
#(
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  c_cmd,
    input  logic [31:0] c_address,
    output logic [3:0]  c_response,
    output logic        c_reset_done,
    output logic [31:0] c_load_data,
    output logic        m_read,
    output logic [31:0] m_address,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    input  logic        m_error
);

    localparam int LINE_OFFSET_W = $clog2(WORDS_PER_LINE) + 2;
    localparam int IDX_W         = beat_width(WORDS_PER_LINE);
    localparam int TAG_W         = 32 - LINE_OFFSET_W;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FILL} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        resp_reg, resp_next;
    logic              reset_done_reg, reset_done_next;
    logic [31:0]       load_data_reg, load_data_next;
    logic              m_read_reg, m_read_next;
    logic [31:0]       m_address_reg, m_address_next;
    logic [IDX_W-1:0]  beat_reg, beat_next;
    logic [IDX_W-1:0]  req_idx_reg, req_idx_next;
    // Set while a FLUSH_ALL is being held, so it executes once per request
    logic              flush_seen_reg, flush_seen_next;

    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  rd_idx;
    logic [31:0]       rd_data;
    logic              buf_we, valid_set, valid_clear, tag_we;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;

    assign addr_idx = IDX_W'((c_address >> 2) & 32'(WORDS_PER_LINE - 1));
    assign addr_tag = c_address[31:LINE_OFFSET_W];

    armleocpu_line_buffer #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W),
        .TAG_W          (TAG_W)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .we          (buf_we),
        .widx        (beat_reg),
        .wdata       (m_rdata),
        .ridx        (rd_idx),
        .rdata       (rd_data),
        .valid_set   (valid_set),
        .valid_clear (valid_clear),
        .tag_we      (tag_we),
        .tag_in      (addr_tag),
        .line_valid  (line_valid),
        .tag         (line_tag)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            resp_reg       <= CACHE_RESPONSE_IDLE;
            reset_done_reg <= 1'b0;
            load_data_reg  <= '0;
            m_read_reg     <= 1'b0;
            m_address_reg  <= '0;
            beat_reg       <= '0;
            req_idx_reg    <= '0;
            flush_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            resp_reg       <= resp_next;
            reset_done_reg <= reset_done_next;
            load_data_reg  <= load_data_next;
            m_read_reg     <= m_read_next;
            m_address_reg  <= m_address_next;
            beat_reg       <= beat_next;
            req_idx_reg    <= req_idx_next;
            flush_seen_reg <= flush_seen_next;
        end
    end

    // Command decode, hit/miss handling and refill sequencing
    always_comb begin
        state_next      = state_reg;
        resp_next       = CACHE_RESPONSE_IDLE;
        reset_done_next = reset_done_reg;
        load_data_next  = load_data_reg;
        m_read_next     = m_read_reg;
        m_address_next  = m_address_reg;
        beat_next       = beat_reg;
        req_idx_next    = req_idx_reg;
        flush_seen_next = flush_seen_reg;
        rd_idx          = addr_idx;
        buf_we          = 1'b0;
        valid_set       = 1'b0;
        valid_clear     = 1'b0;
        tag_we          = 1'b0;

        case (state_reg)
            ST_INIT: begin
                state_next      = ST_IDLE;
                reset_done_next = 1'b1;
            end
            ST_IDLE: begin
                flush_seen_next = 1'b0;
                case (c_cmd)
                    CACHE_CMD_EXECUTE: begin
                        if (c_address[1:0] != 2'b00) begin
                            resp_next = CACHE_RESPONSE_MISSALIGNED;
                        end else if (line_valid && (line_tag == addr_tag)) begin
                            resp_next      = CACHE_RESPONSE_DONE;
                            load_data_next = rd_data;
                        end else begin
                            state_next     = ST_FILL;
                            resp_next      = CACHE_RESPONSE_WAIT;
                            valid_clear    = 1'b1;
                            tag_we         = 1'b1;
                            beat_next      = '0;
                            req_idx_next   = addr_idx;
                            m_read_next    = 1'b1;
                            m_address_next = {addr_tag, {LINE_OFFSET_W{1'b0}}};
                        end
                    end
                    CACHE_CMD_FLUSH_ALL: begin
                        flush_seen_next = 1'b1;
                        if (!flush_seen_reg) begin
                            valid_clear = 1'b1;
                            resp_next   = CACHE_RESPONSE_DONE;
                        end
                    end
                    default: ;
                endcase
            end
            ST_FILL: begin
                resp_next = CACHE_RESPONSE_WAIT;
                rd_idx    = req_idx_reg;
                if (m_ready) begin
                    if (m_error) begin
                        state_next  = ST_IDLE;
                        resp_next   = CACHE_RESPONSE_ACCESSFAULT;
                        m_read_next = 1'b0;
                    end else begin
                        buf_we = 1'b1;
                        if (beat_reg == IDX_W'(WORDS_PER_LINE - 1)) begin
                            state_next  = ST_IDLE;
                            resp_next   = CACHE_RESPONSE_DONE;
                            valid_set   = 1'b1;
                            m_read_next = 1'b0;
                            // The requested word may be the beat arriving now
                            load_data_next = (req_idx_reg == beat_reg) ? m_rdata : rd_data;
                        end else begin
                            beat_next      = beat_reg + IDX_W'(1);
                            m_address_next = m_address_reg + 32'd4;
                        end
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign c_response   = resp_reg;
    assign c_reset_done = reset_done_reg;
    assign c_load_data  = load_data_reg;
    assign m_read       = m_read_reg;
    assign m_address    = m_address_reg;

endmodule

// File: doc/armleocpu_fetch_responder.md
Name: armleocpu_fetch_responder

Overview:
- Responder end of the fetch-to-cache command/response interface: accepts `CACHE_CMD_EXECUTE` and `CACHE_CMD_FLUSH_ALL` from the fetch unit and answers on `c_response` and `c_load_data`.
- Holds a single instruction line buffer of WORDS_PER_LINE words.
- On a line miss, refills the buffer over a simple valid/ready read bus to backing memory.
- Sits between armleocpu_fetch and the memory fabric; it is the uncached/TCM alternative to the full instruction cache.

Parameters:
- WORDS_PER_LINE, 4, words per line buffer; power of two, range 1..16.
- LINE_OFFSET_W, $clog2(WORDS_PER_LINE)+2, byte-offset bits of a line (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- c_cmd  in  4  cache command (`CACHE_CMD_*`).
- c_address  in  32  fetch address, sampled with c_cmd.
- c_response  out  4  registered response (`CACHE_RESPONSE_*`).
- c_reset_done  out  1  high once the responder accepts commands.
- c_load_data  out  32  instruction word; valid only while c_response is DONE.
- m_read  out  1  backing read request (valid).
- m_address  out  32  word-aligned backing read address.
- m_ready  in  1  backing read accepted and completed this cycle.
- m_rdata  in  32  read data; valid when m_ready=1.
- m_error  in  1  bus error; valid when m_ready=1.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to INIT; line_valid=0.
  - c_response=IDLE, c_reset_done=0, m_read=0, m_address=0, c_load_data=0.
- INIT: lasts one cycle, then goes to IDLE with c_reset_done=1. c_reset_done stays 1 until the next rst.
- Command accept:
  - c_cmd is sampled only in IDLE state, which includes the cycle in which c_response=DONE or an error code is presented.
  - The fetch unit issues the next EXECUTE in the same cycle it sees DONE; this must be accepted with zero turnaround.
  - c_cmd is ignored in INIT and FILL. A repeated FLUSH_ALL held by the fetch unit while WAIT is shown is not re-executed.
  - NONE and unknown codes: no action; c_response goes to IDLE the next cycle.
- Response duration: c_response is a one-cycle pulse of DONE, ACCESSFAULT or MISSALIGNED, followed by IDLE unless a new command was accepted in that same cycle.
- EXECUTE, accepted at cycle T; the address is latched.
  - c_address[1:0] != 0: c_response=MISSALIGNED at T+1; no bus activity; buffer untouched.
  - Hit (line_valid and c_address[31:LINE_OFFSET_W] equal to the tag): c_response=DONE at T+1; c_load_data is the buffered word at index c_address[LINE_OFFSET_W-1:2].
  - Miss: go to FILL.
    - c_response=WAIT from T+1 until completion.
    - line_valid=0 and the tag is set to the new address.
    - Beats are issued in line-base order, word 0 to word N-1.
    - m_address = {tag, beat_index, 2'b00}.
    - m_read is held high and m_address stable until m_ready.
    - Once the last beat is accepted with no error: line_valid=1, c_response=DONE on the next cycle, with data for the requested word.
    - m_error on any beat: stop issuing beats; line_valid stays 0; c_response=ACCESSFAULT on the next cycle.
- FLUSH_ALL, accepted at T: line_valid=0 at T+1, c_response=DONE at T+1, c_load_data unchanged.
- PAGEFAULT is never produced; this block performs no translation.
- Beat counter: width $clog2(WORDS_PER_LINE), minimum 1 bit. For WORDS_PER_LINE=1 the last beat is beat 0.
- Reset during FILL: the bus request is abandoned and m_read=0 at the next edge. The fabric must tolerate a withdrawn request.

Decomposition:
- Shared constants come from armleocpu_cache.vh: `CACHE_CMD_NONE`, `CACHE_CMD_EXECUTE`, `CACHE_CMD_FLUSH_ALL`, and the `CACHE_RESPONSE_IDLE/WAIT/DONE/ACCESSFAULT/MISSALIGNED/PAGEFAULT` codes.
- State encodings (INIT/IDLE/FILL) are local localparams.
- One sub-module is natural: armleocpu_line_buffer, a WORDS_PER_LINE×32 register array with a write port (index, data, we) and a combinational read by index, plus the valid/tag registers.

Test Plan:
- Hold rst=1 for 3 cycles, then release → c_reset_done=0 for one cycle then 1; c_response=IDLE; m_read=0.
- EXECUTE at 0x2000 (cold), memory word k = 0xA0+k, m_ready after 2 cycles per beat → m_address 0x2000, 0x2004, 0x2008, 0x200C; WAIT until the last beat; DONE with data 0xA0.
- DONE cycle with back-to-back EXECUTE at 0x2004, then 0x2008 → DONE at T+1 each time with 0xA1 then 0xA2; m_read stays 0.
- EXECUTE at 0x2002 → MISSALIGNED one cycle later, then IDLE; no m_read.
- Line filled, FLUSH_ALL held for 3 cycles → DONE once at T+1; a following EXECUTE at 0x2000 misses and refills.
- Refill with m_error on beat 2 → ACCESSFAULT one cycle after that beat; no beat 3 issued. A re-EXECUTE at 0x2000 then refetches from beat 0.
- rst pulsed mid-FILL → m_read=0 and c_response=IDLE at the next edge; line_valid=0.
